// File: rtl/pixel_plot_buffer.sv
// Clip-and-buffer stage between the draw-engine mux and the VGA adapter.
// On-screen plot requests go through a first-word-fall-through FIFO that drains at most one per clock.
module pixel_plot_buffer #(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   in_x,
  input  logic [6:0]                   in_y,
  input  logic [2:0]                   in_colour,
  input  logic                         in_plot,
  output logic                         in_ready,
  output logic [7:0]                   out_x,
  output logic [6:0]                   out_y,
  output logic [2:0]                   out_colour,
  output logic                         out_plot,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [15:0]                  dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic {S_EMPTY, S_VALID} state_t;

  state_t          state_q, state_d;
  logic [17:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [LW-1:0]   fifo_cnt;
  logic [15:0]     dropped_q, dropped_d;
  logic [17:0]     out_data_q, out_data_d;

  logic accept, on_screen, push, clip, pop, fifo_empty, load, fifo_rd, bypass, fifo_wr;

  // Output register counts toward level, so the FIFO part holds level minus one while VALID.
  assign in_ready   = (level_q < LW'(DEPTH));
  assign accept     = in_plot && in_ready;
  assign on_screen  = (32'(in_x) < SCREEN_W) && (32'(in_y) < SCREEN_H);
  assign push       = accept && on_screen;
  assign clip       = accept && !on_screen;
  assign pop        = (state_q == S_VALID) && out_ready;
  assign fifo_cnt   = level_q - LW'(state_q == S_VALID);
  assign fifo_empty = (fifo_cnt == '0);
  assign load       = (state_q == S_EMPTY) || pop;
  assign fifo_rd    = load && !fifo_empty;
  assign bypass     = load && fifo_empty && push;
  assign fifo_wr    = push && !bypass;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (push || !fifo_empty) state_d = S_VALID;
      S_VALID: if (pop && fifo_empty && !push) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    dropped_d  = dropped_q;
    out_data_d = out_data_q;
    if (fifo_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (fifo_rd) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      out_data_d = mem[rd_ptr_q];
    end else if (bypass) begin
      out_data_d = {in_x, in_y, in_colour};
    end
    if (push && !pop) level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
    if (clip && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
  end

  // Storage has no reset so it can map onto RAM; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr_q] <= {in_x, in_y, in_colour};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      dropped_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      dropped_q  <= dropped_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_plot   = (state_q == S_VALID);
  assign out_x      = out_data_q[17:10];
  assign out_y      = out_data_q[9:3];
  assign out_colour = out_data_q[2:0];
  assign level      = level_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_pixel_plot_buffer.sv
// Scoreboard bench for pixel_plot_buffer: the driver queues expected pixels, the monitor pops on each transfer.
module tb_pixel_plot_buffer;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_x = '0;
  logic [6:0] in_y = '0;
  logic [2:0] in_colour = '0;
  logic       in_plot = 1'b0;
  logic       in_ready;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic       out_plot;
  logic       out_ready = 1'b0;
  logic [4:0] level;
  logic [15:0] dropped;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_total = 0;
  int   xfer_total = 0;
  int   drop_model = 0;
  int   n_out = 0;
  bit   xfer_pend = 0;

  pixel_plot_buffer #(.DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_plot(in_plot), .in_ready(in_ready),
    .out_x(out_x), .out_y(out_y), .out_colour(out_colour), .out_plot(out_plot), .out_ready(out_ready),
    .level(level), .dropped(dropped)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endfunction

  // Entered and left 1 time unit after a rising edge; the model commits on the edge that takes the request.
  task automatic cycle(input int x, input int y, input int c, input bit plot, input bit ordy, output bit acc);
    in_x = 8'(x);
    in_y = 7'(y);
    in_colour = 3'(c);
    in_plot = plot;
    out_ready = ordy;
    #1;
    acc = plot && in_ready;
    @(posedge clk);
    if (acc) begin
      if (x < 160 && y < 120) begin
        exp_q.push_back(pix_t'{x: 8'(x), y: 7'(y), c: 3'(c)});
        acc_total++;
      end else if (drop_model < 65535) begin
        drop_model++;
      end
    end
    #1;
  endtask

  // Monitor: samples 3 units after each edge, pops and compares on every transfer.
  initial begin : monitor
    bit   stalled;
    pix_t held;
    pix_t got;
    pix_t e;
    stalled = 0;
    held = '0;
    forever begin
      @(posedge clk);
      #3;
      if (!rst_n) begin
        xfer_pend = 0;
        stalled = 0;
        continue;
      end
      if (xfer_pend) begin
        xfer_total++;
        xfer_pend = 0;
      end
      got = pix_t'{x: out_x, y: out_y, c: out_colour};
      chk("level", 32'(level), 32'(acc_total - xfer_total));
      chk("dropped", 32'(dropped), 32'(drop_model));
      chk("in_ready", 32'(in_ready), 32'(acc_total - xfer_total < DEPTH));
      if (stalled) chk("stall_stable", {13'b0, out_plot, got}, {13'b0, 1'b1, held});
      if (out_plot) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel actual=%0d,%0d,%0d expected=none", out_x, out_y, out_colour);
          end else begin
            e = exp_q.pop_front();
            chk("pixel", 32'(got), 32'(e));
          end
          xfer_pend = 1;
          n_out++;
          $display("OUT %0d x=%0d y=%0d c=%0d", n_out, out_x, out_y, out_colour);
        end
        stalled = !out_ready;
        held = got;
      end else begin
        stalled = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit acc;
    int sent;
    int guard;
    int base;

    // Reset state
    #2;
    chk("rst_out_plot", 32'(out_plot), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_dropped", 32'(dropped), 0);
    chk("rst_out_x", 32'(out_x), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("ready_after_rst", 32'(in_ready), 1);

    // Single pixel, latency 1
    cycle(5, 7, 2, 1, 1, acc);
    chk("t1_plot", 32'(out_plot), 1);
    chk("t1_xyc", {14'b0, out_x, out_y, out_colour}, {14'b0, 8'd5, 7'd7, 3'd2});
    cycle(0, 0, 0, 0, 1, acc);
    chk("t1_plot_after", 32'(out_plot), 0);
    chk("t1_level_after", 32'(level), 0);

    // Fill to full with downstream stalled
    for (int i = 0; i < 16; i++) cycle(i, i, i % 8, 1, 0, acc);
    chk("t2_ready_full", 32'(in_ready), 0);
    chk("t2_level_full", 32'(level), 16);
    cycle(100, 100, 1, 1, 0, acc);
    chk("t2_17th_rejected", 32'(acc), 0);
    chk("t2_level_still", 32'(level), 16);
    cycle(50, 50, 0, 1, 1, acc);
    chk("t2_full_no_accept", 32'(acc), 0);
    chk("t2_level_drain0", 32'(level), 15);
    chk("t2_ready_back", 32'(in_ready), 1);
    for (int k = 0; k < 15; k++) begin
      cycle(0, 0, 0, 0, 1, acc);
      chk("t2_drain_rate", 32'(level), 32'(14 - k));
    end
    chk("t2_empty", 32'(out_plot), 0);

    // Clipping
    cycle(160, 0, 1, 1, 1, acc);
    cycle(0, 120, 2, 1, 1, acc);
    cycle(159, 119, 6, 1, 1, acc);
    chk("t3_dropped", 32'(dropped), 2);
    chk("t3_out", {14'b0, out_x, out_y, out_colour}, {14'b0, 8'd159, 7'd119, 3'd6});
    cycle(0, 0, 0, 0, 1, acc);
    chk("t3_empty", 32'(out_plot), 0);

    // Sustained stream, no bubbles
    base = n_out;
    for (int i = 0; i < 1000; i++) begin
      cycle($urandom_range(159), $urandom_range(119), $urandom_range(7), 1, 1, acc);
      chk("t4_no_gap", 32'(out_plot), 1);
      chk("t4_level_le1", 32'(level <= 1), 1);
    end
    cycle(0, 0, 0, 0, 1, acc);
    cycle(0, 0, 0, 0, 1, acc);
    chk("t4_count", 32'(n_out - base), 1000);

    // Fill-screen pattern under random back-pressure
    sent = 0;
    guard = 0;
    while (sent < 3000 && guard < 20000) begin
      cycle(sent % 160, (sent / 160) % 120, $urandom_range(7),
            ($urandom_range(3) != 0), ($urandom_range(1) != 0), acc);
      if (acc) sent++;
      guard++;
    end
    chk("t5_sent_in_budget", 32'(sent), 3000);
    guard = 0;
    while ((level != 0 || out_plot) && guard < 40) begin
      cycle(0, 0, 0, 0, 1, acc);
      guard++;
    end
    chk("t5_drained", 32'(level), 0);
    chk("t5_queue_empty", 32'(exp_q.size()), 0);

    // Reset mid-transfer
    for (int i = 0; i < 9; i++) cycle(i + 20, i + 30, i % 8, 1, 0, acc);
    chk("t6_level9", 32'(level), 9);
    in_plot = 1'b0;
    out_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_plot_rst", 32'(out_plot), 0);
    chk("t6_level_rst", 32'(level), 0);
    chk("t6_dropped_rst", 32'(dropped), 0);
    exp_q.delete();
    acc_total = 0;
    xfer_total = 0;
    drop_model = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(10, 20, 5, 1, 1, acc);
    chk("t6_latency_plot", 32'(out_plot), 1);
    chk("t6_latency_xyc", {14'b0, out_x, out_y, out_colour}, {14'b0, 8'd10, 7'd20, 3'd5});
    cycle(0, 0, 0, 0, 1, acc);
    chk("t6_final_level", 32'(level), 0);
    cycle(0, 0, 0, 0, 1, acc);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
